imm_fetch_ctrl: RTL and testbench
=================================

IMM_FETCH_CTRL -- requirements
Module: imm_fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: number of consecutive mem_req-high cycles without mem_ack before the fetch aborts; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one immediate fetch; sampled on rising clk.
REQ-005 mode  input  1  0 = short form (one byte, extended to 16 bits); 1 = long form (two bytes).
REQ-006 zext  input  1  short form only: 1 = zero-extend, 0 = sign-extend; ignored when mode=1.
REQ-007 base_addr  input  16  byte address of the immediate's first (low) byte.
REQ-008 mem_req  output  1  byte read request to the memory port.
REQ-009 mem_addr  output  16  byte address of the current request.
REQ-010 mem_ack  input  1  memory has placed the read byte on mem_rdata this cycle.
REQ-011 mem_rdata  input  8  read data; valid only when mem_ack=1.
REQ-012 busy  output  1  high while a fetch is in progress.
REQ-013 imm  output  16  assembled immediate; holds its value until the next successful fetch.
REQ-014 imm_valid  output  1  one-cycle pulse: imm has just been updated.
REQ-015 err  output  1  one-cycle pulse: fetch aborted on timeout.

Function
REQ-016 The FSM SHALL have five states: IDLE, REQ_LO, REQ_HI, DONE, ERR.
REQ-017 In IDLE, DONE or ERR, start=1 SHALL latch mode, zext and base_addr and move to REQ_LO.
REQ-018 Otherwise, DONE and ERR SHALL return to IDLE after one cycle.
REQ-019 start while busy=1 SHALL be ignored, and the latched operands SHALL NOT change.
REQ-020 busy SHALL be 1 exactly in REQ_LO and REQ_HI.
REQ-021 mem_req SHALL be 1 exactly in REQ_LO and REQ_HI.
REQ-022 mem_addr SHALL be latched base_addr in REQ_LO and latched base_addr+1 in REQ_HI.
REQ-023 The addition in REQ-022 SHALL wrap modulo 2^16 (0xFFFF+1 = 0x0000).
REQ-024 mem_addr SHALL be stable while mem_req=1, and SHALL be 0 when mem_req=0.
REQ-025 mem_ack sampled while mem_req=0 SHALL be ignored.
REQ-026 In REQ_LO, mem_ack=1 SHALL capture mem_rdata as the low byte.
REQ-027 After REQ-026, the FSM SHALL go to DONE if mode=0 and to REQ_HI if mode=1.
REQ-028 In REQ_HI, mem_ack=1 SHALL capture mem_rdata as the high byte and go to DONE.
REQ-029 Short form: imm = {8 copies of bit 7 of the low byte, low byte} when zext=0, and {8'h00, low byte} when zext=1.
REQ-030 Long form: imm = {high byte, low byte} (little-endian).
REQ-031 imm SHALL be updated on the DONE entry edge; imm_valid SHALL be 1 for exactly the DONE cycle.
REQ-032 Latency: start high in cycle 0 gives mem_req high from cycle 1; an ack in cycle k gives one of:
- short form: imm_valid in cycle k+1;
- long form: mem_req stays high from cycle k+1 (address +1); the second ack in cycle j gives imm_valid in cycle j+1.
REQ-033 mem_ack in the same cycle as mem_req rises SHALL count as an acknowledgement.
REQ-034 The minimum fetch is 2 cycles for short form and 3 cycles for long form.
REQ-035 A wait counter SHALL clear on entry to REQ_LO and REQ_HI, and count each cycle in those states with mem_ack=0.
REQ-036 When the counter reaches TIMEOUT-1 with mem_ack=0, the FSM SHALL go to ERR; err SHALL be 1 for the ERR cycle.
REQ-037 On the ERR path, imm SHALL be unchanged and imm_valid SHALL stay 0.
REQ-038 mem_ack=1 in the same cycle that the timeout would fire SHALL take priority (normal completion, no err).

Reset
REQ-039 While rst=0, the FSM SHALL be IDLE, and the counter, latched operands and captured bytes SHALL be 0.
REQ-040 While rst=0, mem_req, mem_addr, busy, imm, imm_valid and err SHALL all be 0, independent of clk.
REQ-041 Reset asserted mid-fetch SHALL abandon the fetch, with no imm_valid and no err.
REQ-042 After rst rises, the first start SHALL be accepted on the next rising clk.

Verification
REQ-043 Short signed: mode=0, zext=0, base 0x0100, ack one cycle after mem_req with rdata 0x85 -> mem_addr 0x0100; imm=0xFF85; imm_valid pulses once.
REQ-044 Short zero-extend: as REQ-043 but zext=1 -> imm=0x0085; an rdata of 0x7F with zext=0 -> imm=0x007F.
REQ-045 Long, address wrap: mode=1, base 0xFFFF, acks with 0x34 then 0x12 -> mem_addr 0xFFFF then 0x0000; imm=0x1234 three cycles after start with zero-wait acks.
REQ-046 Timeout: mode=0, mem_ack held 0 -> mem_req high for exactly TIMEOUT (15) cycles, then a one-cycle err; imm keeps its prior value; busy drops.
REQ-047 Busy and reset: start with base 0x2000 pulsed again mid-fetch -> ignored (address stays 0x2000); rst=0 asserted in REQ_HI -> all outputs 0 immediately, no imm_valid or err afterwards.

Source files
------------

// File: rtl/imm_fetch_ctrl.sv
// Immediate-operand fetch controller.
// Reads a one-byte (short form, sign/zero-extended) or two-byte (long form,
// little-endian) immediate over a byte-wide request/acknowledge memory port.
// Each byte request aborts to ERR after TIMEOUT consecutive unacknowledged cycles.
module imm_fetch_ctrl #(
   parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
   input  logic        clk,
   input  logic        rst,        // asynchronous, active-low
   input  logic        start,
   input  logic        mode,       // 0 = short form, 1 = long form
   input  logic        zext,       // short form: 1 = zero-extend, 0 = sign-extend
   input  logic [15:0] base_addr,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic [15:0] imm,
   output logic        imm_valid,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_LO = 3'd1,
      REQ_HI = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

   // Last wait-count value before a request is declared dead.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic        mode_q;
   logic        zext_q;
   logic [15:0] base_q;
   logic [7:0]  cnt;
   logic [7:0]  lo_q;
   logic [15:0] imm_q;

   logic        in_req;
   logic        accept;

   // A request is outstanding only in the two byte-request states.
   assign in_req = (state == REQ_LO) || (state == REQ_HI);
   // A new start is honoured only when no fetch is in flight.
   assign accept = start && !in_req;

   // State register.
   // NOTE: every register in this block and the datapath uses <= so all
   // flops see pre-edge values; a blocking = here would create ordering races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic: an acknowledge always wins over an expiring wait count.
   // NOTE: next_state gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) next_state = REQ_LO;
            else       next_state = IDLE;
         end
         REQ_LO: begin
            if (mem_ack)              next_state = mode_q ? REQ_HI : DONE;
            else if (cnt == CNT_LAST) next_state = ERR;
         end
         REQ_HI: begin
            if (mem_ack)              next_state = DONE;
            else if (cnt == CNT_LAST) next_state = ERR;
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand latch, wait counter and byte capture / immediate assembly.
   // NOTE: all datapath registers are reset (no memories here), so imm and
   // the address are cleanly 0 for the whole reset interval.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= 1'b0;
         zext_q <= 1'b0;
         base_q <= '0;
         cnt    <= '0;
         lo_q   <= '0;
         imm_q  <= '0;
      end else begin
         if (accept) begin
            mode_q <= mode;
            zext_q <= zext;
            base_q <= base_addr;
         end

         // Counter restarts on every state change, so each byte gets a fresh budget.
         if (state != next_state)   cnt <= '0;
         else if (in_req && !mem_ack) cnt <= cnt + 8'd1;

         if (state == REQ_LO && mem_ack) begin
            lo_q <= mem_rdata;
            if (!mode_q) begin
               imm_q <= zext_q ? {8'h00, mem_rdata}
                               : {{8{mem_rdata[7]}}, mem_rdata};
            end
         end

         if (state == REQ_HI && mem_ack) imm_q <= {mem_rdata, lo_q};
      end
   end

   // Outputs decode purely from registered state, so reset clears them at once.
   assign busy      = in_req;
   assign mem_req   = in_req;
   assign mem_addr  = (state == REQ_LO) ? base_q
                    : (state == REQ_HI) ? base_q + 16'd1   // wraps modulo 2^16
                    : 16'h0000;
   assign imm       = imm_q;
   assign imm_valid = (state == DONE);
   assign err       = (state == ERR);

endmodule

// File: tb/tb_imm_fetch_ctrl.sv
// Directed self-checking bench for imm_fetch_ctrl.
module tb_imm_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        zext = 1'b0;
   logic [15:0] base_addr = '0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic        busy;
   logic [15:0] imm;
   logic        imm_valid;
   logic        err;

   int checks = 0;
   int errors = 0;

   imm_fetch_ctrl #(.TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .zext      (zext),
      .base_addr (base_addr),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .imm       (imm),
      .imm_valid (imm_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (mem_req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (mem_addr !== 16'h0)  begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (imm !== 16'h0)       begin errors++; $display("FAIL reset_imm got=%h exp=0000", imm); end
      checks++; if (imm_valid !== 1'b0)  begin errors++; $display("FAIL reset_imm_valid got=%b exp=0", imm_valid); end
      checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Short signed fetch with one wait cycle; also ack-while-idle is ignored.
   task automatic test_short_signed();
      int pulses = 0;
      mem_ack = 1'b1; mem_rdata = 8'h55;    // stray ack while idle
      tick();
      checks++; if (busy !== 1'b0 || imm !== 16'h0 || imm_valid !== 1'b0)
         begin errors++; $display("FAIL idle_ack_ignored got busy=%b imm=%h valid=%b exp 0/0000/0", busy, imm, imm_valid); end
      mem_ack = 1'b0;
      start = 1'b1; mode = 1'b0; zext = 1'b0; base_addr = 16'h0100;
      tick();
      start = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100)
         begin errors++; $display("FAIL ss_req got req=%b addr=%h exp 1/0100", mem_req, mem_addr); end
      tick();   // one wait cycle
      checks++; if (mem_addr !== 16'h0100 || busy !== 1'b1)
         begin errors++; $display("FAIL ss_addr_stable got addr=%h busy=%b exp 0100/1", mem_addr, busy); end
      mem_ack = 1'b1; mem_rdata = 8'h85;
      tick();
      mem_ack = 1'b0;
      if (imm_valid === 1'b1) pulses++;
      checks++; if (imm !== 16'hFF85) begin errors++; $display("FAIL ss_imm got=%h exp=FF85", imm); end
      checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || busy !== 1'b0)
         begin errors++; $display("FAIL ss_done_outputs got req=%b addr=%h busy=%b exp 0/0000/0", mem_req, mem_addr, busy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (imm_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ss_valid_pulses got=%0d exp=1", pulses); end
      checks++; if (imm !== 16'hFF85) begin errors++; $display("FAIL ss_imm_hold got=%h exp=FF85", imm); end
   endtask

   // Short zero-extend with zero-wait ack: minimum 2-cycle fetch.
   task automatic test_short_zext();
      start = 1'b1; mode = 1'b0; zext = 1'b1; base_addr = 16'h0100;
      tick();
      start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'h85;
      tick();
      mem_ack = 1'b0;
      checks++; if (imm_valid !== 1'b1 || imm !== 16'h0085)
         begin errors++; $display("FAIL sz_imm got valid=%b imm=%h exp 1/0085", imm_valid, imm); end
      tick();
   endtask

   // Long form at 0xFFFF: second byte address wraps to 0x0000.
   task automatic test_long_wrap();
      start = 1'b1; mode = 1'b1; zext = 1'b0; base_addr = 16'hFFFF;
      tick();
      start = 1'b0;
      checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL lw_addr_lo got=%h exp=FFFF", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'h34;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000)
         begin errors++; $display("FAIL lw_addr_hi got req=%b addr=%h exp 1/0000", mem_req, mem_addr); end
      mem_rdata = 8'h12;
      tick();
      mem_ack = 1'b0;
      checks++; if (imm_valid !== 1'b1 || imm !== 16'h1234)
         begin errors++; $display("FAIL lw_imm got valid=%b imm=%h exp 1/1234", imm_valid, imm); end
      tick();
   endtask

   // No ack: exactly 15 request cycles, then a one-cycle err, imm untouched.
   task automatic test_timeout();
      int req_cycles = 0;
      bit saw_err = 1'b0;
      start = 1'b1; mode = 1'b0; zext = 1'b0; base_addr = 16'h4000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40 && !saw_err; i++) begin
         if (mem_req === 1'b1) req_cycles++;
         if (err === 1'b1) saw_err = 1'b1;
         else tick();
      end
      checks++; if (!saw_err) begin errors++; $display("FAIL to_err_seen got=0 exp=1 within 40 cycles"); end
      checks++; if (req_cycles != 15) begin errors++; $display("FAIL to_req_cycles got=%0d exp=15", req_cycles); end
      checks++; if (imm !== 16'h1234 || imm_valid !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL to_outputs got imm=%h valid=%b busy=%b exp 1234/0/0", imm, imm_valid, busy); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got=%b exp=0", err); end
   endtask

   // Ack on the very cycle the timeout would fire wins; rdata 0x7F sign-extends to 0x007F.
   task automatic test_ack_at_timeout();
      start = 1'b1; mode = 1'b0; zext = 1'b0; base_addr = 16'h5000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL at_req15 got=%b exp=1", mem_req); end
      mem_ack = 1'b1; mem_rdata = 8'h7F;
      tick();
      mem_ack = 1'b0;
      checks++; if (err !== 1'b0 || imm_valid !== 1'b1 || imm !== 16'h007F)
         begin errors++; $display("FAIL at_priority got err=%b valid=%b imm=%h exp 0/1/007F", err, imm_valid, imm); end
   endtask

   // Start in the DONE cycle chains straight into the next fetch.
   task automatic test_back_to_back();
      start = 1'b1; mode = 1'b0; zext = 1'b1; base_addr = 16'h6000;
      tick();
      checks++; if (busy !== 1'b1 || mem_addr !== 16'h6000)
         begin errors++; $display("FAIL bb_restart got busy=%b addr=%h exp 1/6000", busy, mem_addr); end
      start = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'hC3;
      tick();
      mem_ack = 1'b0;
      checks++; if (imm_valid !== 1'b1 || imm !== 16'h00C3)
         begin errors++; $display("FAIL bb_imm got valid=%b imm=%h exp 1/00C3", imm_valid, imm); end
      tick();
   endtask

   // Start while busy is ignored; reset in REQ_HI abandons the fetch.
   task automatic test_busy_reset();
      int bad = 0;
      start = 1'b1; mode = 1'b1; zext = 1'b0; base_addr = 16'h2000;
      tick();
      start = 1'b1; mode = 1'b0; base_addr = 16'h3000;   // mid-fetch start
      tick();
      start = 1'b0;
      checks++; if (mem_addr !== 16'h2000) begin errors++; $display("FAIL br_ignore got=%h exp=2000", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 8'hAA;
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h2001)
         begin errors++; $display("FAIL br_hi got req=%b addr=%h exp 1/2001", mem_req, mem_addr); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({mem_req, busy, imm_valid, err} !== 4'b0 || mem_addr !== 16'h0 || imm !== 16'h0)
         begin errors++; $display("FAIL br_async_reset got req=%b busy=%b valid=%b err=%b addr=%h imm=%h exp all 0", mem_req, busy, imm_valid, err, mem_addr, imm); end
      tick();
      rst = 1'b1;
      mem_ack = 1'b1; mem_rdata = 8'h99;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (imm_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) bad++;
      end
      mem_ack = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL br_after_reset got=%0d bad cycles exp=0", bad); end
      start = 1'b1; mode = 1'b0; base_addr = 16'h7000;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1 || mem_addr !== 16'h7000)
         begin errors++; $display("FAIL br_first_start got busy=%b addr=%h exp 1/7000", busy, mem_addr); end
   endtask

   initial begin
      test_reset();
      test_short_signed();
      test_short_zext();
      test_long_wrap();
      test_timeout();
      test_ack_at_timeout();
      test_back_to_back();
      test_busy_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
